hazard_scoreboard: RTL

//   Parametrised stall controller for the pipelined MIPS core. It replaces per-stage Tnew decoding with a

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 86 ++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: the decoder drives the D-stage fields and the scoreboard
// returns the stall decision.
interface hazard_scoreboard_if #(
  parameter int TW = 2,
  parameter int AW = 5
);
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_rs_use;
  logic          d_rt_use;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [AW-1:0] d_a3;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_is_div;
  logic          d_md_use;
  logic          stall;
  logic [1:0]    stall_cause;
  logic          md_busy;

  modport master (
    output d_rs, d_rt, d_rs_use, d_rt_use, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_md_start, d_md_is_div, d_md_use,
    input  stall, stall_cause, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_rs_use, d_rt_use, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_md_start, d_md_is_div, d_md_use,
    output stall, stall_cause, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall controller: a shift-register scoreboard of in-flight destinations with decaying Tnew,
// plus a mult/div busy counter that holds HI/LO users in D.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int TW       = 2,
  parameter int AW       = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave sb
);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT);

  logic [AW-1:0] slot_a3   [DEPTH];
  logic [TW-1:0] slot_tnew [DEPTH];
  logic [CW-1:0] md_cnt;
  logic          rs_haz;
  logic          rt_haz;
  logic          rs_found;
  logic          rt_found;
  logic          reg_haz;
  logic          md_haz;
  logic          md_busy_i;
  logic          stall_i;

  // The lowest-index match is the youngest producer and shadows any older match.
  always_comb begin
    rs_haz   = 1'b0;
    rt_haz   = 1'b0;
    rs_found = 1'b0;
    rt_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rs_found && slot_a3[i] == sb.d_rs) begin
        rs_found = 1'b1;
        rs_haz   = slot_tnew[i] > sb.d_tuse_rs;
      end
      if (!rt_found && slot_a3[i] == sb.d_rt) begin
        rt_found = 1'b1;
        rt_haz   = slot_tnew[i] > sb.d_tuse_rt;
      end
    end
    rs_haz = rs_haz & sb.d_rs_use & (sb.d_rs != '0);
    rt_haz = rt_haz & sb.d_rt_use & (sb.d_rt != '0);
  end

  assign reg_haz   = rs_haz | rt_haz;
  assign md_busy_i = (md_cnt != '0);
  assign md_haz    = sb.d_md_use & md_busy_i;
  assign stall_i   = reg_haz | md_haz;

  assign sb.stall       = stall_i;
  assign sb.stall_cause = {md_haz, reg_haz};
  assign sb.md_busy     = md_busy_i;

  // The scoreboard keeps shifting while stalled; only slot 0 takes the bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_a3[i]   <= '0;
        slot_tnew[i] <= '0;
      end
    end else begin
      slot_a3[0]   <= stall_i ? '0 : sb.d_a3;
      slot_tnew[0] <= stall_i ? '0 : sb.d_tnew;
      for (int i = 1; i < DEPTH; i++) begin
        slot_a3[i]   <= slot_a3[i-1];
        slot_tnew[i] <= (slot_tnew[i-1] == '0) ? '0 : slot_tnew[i-1] - 1'b1;
      end
    end
  end

  // A start while busy is itself an md user and stalls, so a reload never collides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (sb.d_md_start && !stall_i) begin
      md_cnt <= sb.d_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end
endmodule
